// File: rtl/neuron_mac_acc.sv
// Pre-activation MAC for one neuron: bias + sum(x*w) in signed fixed point,
// with a 3-stage pipeline (capture, product, accumulate), then a saturating output register.
module neuron_mac_acc #(
  parameter int DWIDTH = 32,
  parameter int frac   = 24,
  parameter int GUARD  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DWIDTH-1:0] in_x,
  input  logic [DWIDTH-1:0] in_w,
  input  logic [DWIDTH-1:0] in_bias,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_data,
  output logic              out_sat
);

  localparam int AW     = DWIDTH + GUARD;
  localparam int PW     = 2 * DWIDTH;
  localparam int STAGES = 2;

  typedef enum logic [1:0] {ACC, DRAIN, OUT} state_t;

  typedef struct packed {
    logic [DWIDTH-1:0] x;
    logic [DWIDTH-1:0] w;
    logic [DWIDTH-1:0] bias;
    logic              first;
    logic              last;
  } beat_t;

  state_t            state;
  logic              first;
  logic [STAGES:0]   vld_pipe;
  beat_t             s0;
  logic [AW-1:0]     prod_q;
  logic [DWIDTH-1:0] bias1;
  logic              first1, last1, last2;
  logic [AW-1:0]     acc;

  logic accept, consume;
  assign accept  = in_valid & in_ready;
  assign consume = out_valid & out_ready;

  // Full product, floor-shifted back into the Q format, then sign-truncated.
  logic signed [PW-1:0] prod_full, prod_shr;
  logic [AW-1:0]        prod_trunc;
  always_comb begin
    prod_full  = $signed(s0.x) * $signed(s0.w);
    prod_shr   = prod_full >>> frac;
    prod_trunc = prod_shr[AW-1:0];
  end

  logic [AW-1:0] bias_ext;
  assign bias_ext = {{GUARD{bias1[DWIDTH-1]}}, bias1};

  // Accumulator fits DWIDTH bits only if its top GUARD+1 bits agree.
  logic [GUARD:0]    acc_hi;
  logic              pos_ovf, neg_ovf;
  logic [DWIDTH-1:0] sat_data;
  always_comb begin
    acc_hi   = acc[AW-1:DWIDTH-1];
    pos_ovf  = !acc[AW-1] && (|acc_hi);
    neg_ovf  = acc[AW-1] && !(&acc_hi);
    sat_data = acc[DWIDTH-1:0];
    if (pos_ovf) sat_data = {1'b0, {(DWIDTH-1){1'b1}}};
    if (neg_ovf) sat_data = {1'b1, {(DWIDTH-1){1'b0}}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      s0       <= '0;
      prod_q   <= '0;
      bias1    <= '0;
      first1   <= 1'b0;
      last1    <= 1'b0;
      last2    <= 1'b0;
      acc      <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], accept};
      if (accept) s0 <= '{x: in_x, w: in_w, bias: in_bias, first: first, last: in_last};
      if (vld_pipe[0]) begin
        prod_q <= prod_trunc;
        bias1  <= s0.bias;
        first1 <= s0.first;
        last1  <= s0.last;
      end
      if (vld_pipe[1]) begin
        acc   <= (first1 ? bias_ext : acc) + prod_q;
        last2 <= last1;
      end else if (consume) begin
        acc <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACC;
      first     <= 1'b1;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else begin
      case (state)
        ACC: begin
          in_ready <= 1'b1;
          if (accept) begin
            first <= 1'b0;
            if (in_last) begin
              in_ready <= 1'b0;
              state    <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (vld_pipe[STAGES] && last2) begin
            out_valid <= 1'b1;
            out_data  <= sat_data;
            out_sat   <= pos_ovf | neg_ovf;
            state     <= OUT;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            first     <= 1'b1;
            in_ready  <= 1'b1;
            state     <= ACC;
          end
        end
        default: state <= ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_mac_acc.sv
// Directed bench for neuron_mac_acc: latency, accumulation, floor rounding,
// saturation, backpressure and async reset.
module tb_neuron_mac_acc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_x = '0, in_w = '0, in_bias = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_sat;

  int checks = 0;
  int failures = 0;
  int lat;

  neuron_mac_acc #(.DWIDTH(32), .frac(24), .GUARD(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_w(in_w), .in_bias(in_bias), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sat(out_sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Presents a beat and returns #1 after its accept edge.
  task automatic send(input logic [31:0] x, input logic [31:0] w,
                      input logic [31:0] b, input logic last);
    int n = 0;
    in_x = x; in_w = w; in_bias = b; in_last = last; in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("accept_wait", 64'(n < 20), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int l);
    l = 0;
    while (!out_valid && l < 20) begin
      @(posedge clk); #1; l++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("consume_valid_low", 64'(out_valid), 64'd0);
    check("consume_ready_high", 64'(in_ready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_sat", 64'(out_sat), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_release_ready", 64'(in_ready), 64'd1);

    // 0.5 + 2.0*1.5 = 3.5
    send(32'h02000000, 32'h01800000, 32'h00800000, 1'b1);
    check("single_ready_drop", 64'(in_ready), 64'd0);
    wait_out(lat);
    check("single_latency", 64'(lat), 64'd3);
    check("single_data", 64'(out_data), 64'h03800000);
    check("single_sat", 64'(out_sat), 64'd0);
    consume();

    // 1 - 0.5 + 0.5 - 1 = 0
    send(32'h01000000, 32'h01000000, 32'h00000000, 1'b0);
    send(32'hFF000000, 32'h00800000, 32'h00000000, 1'b0);
    send(32'h02000000, 32'h00400000, 32'h00000000, 1'b0);
    send(32'h00800000, 32'hFE000000, 32'h00000000, 1'b1);
    wait_out(lat);
    check("vec4_latency", 64'(lat), 64'd3);
    check("vec4_data", 64'(out_data), 64'h00000000);
    check("vec4_sat", 64'(out_sat), 64'd0);
    consume();

    // Tiny positive product floors to 0; out_ready held high gives a 1-cycle pulse.
    out_ready = 1'b1;
    send(32'h00000001, 32'h00800000, 32'h00000000, 1'b1);
    wait_out(lat);
    check("round_pos_latency", 64'(lat), 64'd3);
    check("round_pos_data", 64'(out_data), 64'h00000000);
    @(posedge clk); #1;
    check("pulse_valid_low", 64'(out_valid), 64'd0);
    check("pulse_ready_high", 64'(in_ready), 64'd1);
    out_ready = 1'b0;

    // Tiny negative product floors to -1 LSB.
    send(32'hFFFFFFFF, 32'h00800000, 32'h00000000, 1'b1);
    wait_out(lat);
    check("round_neg_data", 64'(out_data), 64'hFFFFFFFF);
    check("round_neg_sat", 64'(out_sat), 64'd0);
    consume();

    send(32'h7F000000, 32'h7F000000, 32'h00000000, 1'b1);
    wait_out(lat);
    check("sat_pos_data", 64'(out_data), 64'h7FFFFFFF);
    check("sat_pos_sat", 64'(out_sat), 64'd1);
    consume();

    // Negative saturation held under backpressure, with the next beat waiting.
    send(32'h7F000000, 32'h81000000, 32'h00000000, 1'b1);
    wait_out(lat);
    check("sat_neg_data", 64'(out_data), 64'h80000000);
    check("sat_neg_sat", 64'(out_sat), 64'd1);
    in_x = 32'h01000000; in_w = 32'h01000000; in_bias = 32'h01000000;
    in_last = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_valid", 64'(out_valid), 64'd1);
      check("bp_data", 64'(out_data), 64'h80000000);
      check("bp_sat", 64'(out_sat), 64'd1);
      check("bp_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_consumed", 64'(out_valid), 64'd0);
    check("bp_ready_back", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    check("bp_next_accepted", 64'(in_ready), 64'd0);
    in_valid = 1'b0;
    wait_out(lat);
    check("bp_next_latency", 64'(lat), 64'd3);
    check("bp_next_data", 64'(out_data), 64'h02000000);
    check("bp_next_sat", 64'(out_sat), 64'd0);

    // Reset while a result is pending.
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid_async", 64'(out_valid), 64'd0);
    check("rst_out_data_async", 64'(out_data), 64'd0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst2_ready", 64'(in_ready), 64'd1);

    // Reset mid-vector discards the partial sum.
    send(32'h01000000, 32'h01000000, 32'h00800000, 1'b0);
    send(32'h01000000, 32'h01000000, 32'h00800000, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_valid", 64'(out_valid), 64'd0);
    check("rst_mid_ready", 64'(in_ready), 64'd0);
    #1 rst_n = 1'b1;
    #1;
    check("rst_mid_ready_before_edge", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    check("rst_mid_ready_after_edge", 64'(in_ready), 64'd1);
    send(32'h00800000, 32'h02000000, 32'h00000000, 1'b1);
    wait_out(lat);
    check("fresh_latency", 64'(lat), 64'd3);
    check("fresh_data", 64'(out_data), 64'h01000000);
    check("fresh_sat", 64'(out_sat), 64'd0);
    consume();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/neuron_mac_acc.md
Name: neuron_mac_acc

Overview:
Sequential multiply-accumulate stage that produces the pre-activation sum of one neuron: bias + Σ(x_i·w_i) in signed fixed point (DWIDTH bits, frac fractional bits).
- Input: a stream of (x, w) pairs over a valid/ready handshake; in_last marks the final pair of a vector.
- Output: one saturated DWIDTH-bit result per vector over a valid/ready handshake.
- Position: directly upstream of the sigmoid/activation stage, which consumes out_data; same Q format as the datapath mult/add stages.

Parameters:
- DWIDTH, 32, data word width (signed two's complement)
- frac, 24, fractional bits (default format Q8.24)
- GUARD, 8, extra integer bits in the internal product and accumulator

Ports:
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input pair valid
- in_ready  out  1  block can accept a pair
- in_x  in  DWIDTH  signed activation
- in_w  in  DWIDTH  signed weight
- in_bias  in  DWIDTH  signed bias; sampled only on the first accepted beat of a vector
- in_last  in  1  final pair of the current vector
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  DWIDTH  saturated signed sum
- out_sat  out  1  out_data was clamped

Behaviour:
- Reset (async assert, rst_n low): out_valid=0, out_data=0, out_sat=0, in_ready=0, pipeline valids=0, accumulator=0, first-beat flag=1, state=ACC. in_ready becomes 1 on the first clk edge after rst_n deasserts.
- Handshake:
  - An input beat is accepted in a cycle with in_valid & in_ready.
  - An output is consumed in a cycle with out_valid & out_ready.
  - in_ready is registered and never depends combinationally on in_valid.
  - out_data and out_sat hold stable while out_valid=1 and out_ready=0.
- States:
  - ACC: in_ready=1; accepts beats. An accepted beat with in_last=1 moves to DRAIN and drops in_ready at that same edge.
  - DRAIN: in_ready=0; waits for the pipeline to finish, then moves to OUT.
  - OUT: out_valid=1. On consumption: out_valid drops, first-beat flag=1, accumulator cleared, return to ACC with in_ready=1 at that edge.
- Pipeline (accept edge = E):
  - E+1: product register P = full-precision product x·w (2·DWIDTH bits), arithmetically shifted right by frac (floor toward −∞), sign-truncated to DWIDTH+GUARD bits.
  - E+2: accumulator A (DWIDTH+GUARD bits) updated.
    - First beat of a vector: A = sext(bias) + P.
    - Otherwise: A = A + P, wrapping modulo 2^(DWIDTH+GUARD).
  - E+3, for the in_last beat only: out_data and out_sat registered, out_valid=1.
  - Latency from the last-beat accept edge to out_valid high: 3 clk.
- Saturation at output:
  - A > 2^(DWIDTH-1)−1 → out_data = 0x7FFF_FFFF (default width), out_sat=1.
  - A < −2^(DWIDTH-1) → out_data = 0x8000_FFFF is wrong form; use 0x8000_0000, out_sat=1.
  - Otherwise out_data = low DWIDTH bits of A, out_sat=0.
- Boundary conditions:
  - Single-beat vector (first beat also in_last): result = bias + x·w.
  - Back-to-back vectors are separated by the OUT handshake; no overlap.
  - in_valid while in_ready=0: ignored; the upstream stage must hold its data.
  - out_ready held high at E+3: out_valid pulses for exactly 1 cycle.
  - rst_n asserted mid-vector or while out_valid=1: all state cleared, partial sum discarded, no output produced.
  - More than 2^GUARD large terms may wrap A; this is defined behaviour, not flagged.

Test Plan:
- Single vector: bias=0x00800000 (0.5), x=0x02000000 (2.0), w=0x01800000 (1.5), last=1 → out_data=0x03800000, out_sat=0, out_valid high exactly 3 clk after the accept edge.
- 4-beat vector, bias=0: pairs (1.0,1.0), (−1.0=0xFF000000, 0.5), (2.0, 0.25), (0.5, −2.0) → out_data=0x00000000 (1 − 0.5 + 0.5 − 1), out_sat=0.
- Rounding: x=0x00000001, w=0x00800000 → 0x00000000; x=0xFFFFFFFF, w=0x00800000 → 0xFFFFFFFF (floor), each as a separate single-beat vector with bias=0.
- Saturation: bias=0, x=w=0x7F000000 (127.0) → out_data=0x7FFFFFFF, out_sat=1; x=0x7F000000, w=0x81000000 → out_data=0x80000000, out_sat=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid → out_data/out_sat stable, in_ready=0 throughout; the next vector's first beat is accepted in the cycle after consumption and its bias is applied fresh.
- Reset mid-operation: pulse rst_n low after beat 2 of 4 → out_valid=0 immediately (async), in_ready=1 on the first edge after release, then a fresh 1-beat vector (0.5, 2.0, bias=0) yields 0x01000000.
